// File: rtl/execute_stage.sv
// Registered multi-lane execute stage: per-lane ALU, lane-0 HI/LO, MULT/MULTU and optional DIV/DIVU.
// Define EXEC_DIV_EN to compile in the iterative divider and its stall FSM.

module exec_lane #(
  parameter int XLEN  = 32,
  parameter bit IS_L0 = 1'b0
) (
  input  logic            valid_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  output logic [XLEN-1:0] result_o
);
  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    if (valid_i) begin
      case (op_i)
        5'd0:    result_o = a_i + b_i;
        5'd1:    result_o = a_i - b_i;
        5'd2:    result_o = a_i & b_i;
        5'd3:    result_o = a_i | b_i;
        5'd4:    result_o = a_i ^ b_i;
        5'd5:    result_o = ~(a_i | b_i);
        5'd6:    result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
        5'd7:    result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
        5'd8:    result_o = a_i << shamt;
        5'd9:    result_o = a_i >> shamt;
        5'd10:   result_o = $signed(a_i) >>> shamt;
        5'd11:   result_o = XLEN'({b_i[15:0], 16'h0000});
        // HI/LO reads exist only on lane 0; other lanes see zero
        5'd12:   result_o = IS_L0 ? hi_i : '0;
        5'd13:   result_o = IS_L0 ? lo_i : '0;
        default: result_o = '0;
      endcase
    end
  end
endmodule

module execute_stage #(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [LANES-1:0]      in_lane_valid_i,
  input  logic [5*LANES-1:0]    in_op_i,
  input  logic [XLEN*LANES-1:0] in_a_i,
  input  logic [XLEN*LANES-1:0] in_b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [LANES-1:0]      out_lane_valid_o,
  output logic [XLEN*LANES-1:0] out_result_o
);
  localparam logic [4:0] OP_MTHI  = 5'd14;
  localparam logic [4:0] OP_MTLO  = 5'd15;
  localparam logic [4:0] OP_MULT  = 5'd16;
  localparam logic [4:0] OP_MULTU = 5'd17;

  logic [XLEN-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic                  out_valid_q;
  logic [LANES-1:0]      out_lv_q;
  logic [XLEN*LANES-1:0] out_res_q, lane_res;
  logic                  accept, div_op, div_idle;

  logic            l0_v;
  logic [4:0]      l0_op;
  logic [XLEN-1:0] l0_a, l0_b;
  assign l0_v  = in_lane_valid_i[0];
  assign l0_op = in_op_i[4:0];
  assign l0_a  = in_a_i[XLEN-1:0];
  assign l0_b  = in_b_i[XLEN-1:0];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    exec_lane #(.XLEN(XLEN), .IS_L0(g == 0)) u_lane (
      .valid_i  (in_lane_valid_i[g]),
      .op_i     (in_op_i[5*g +: 5]),
      .a_i      (in_a_i[XLEN*g +: XLEN]),
      .b_i      (in_b_i[XLEN*g +: XLEN]),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .result_o (lane_res[XLEN*g +: XLEN])
    );
  end

  // operands widened first so the truncated product is the exact 2*XLEN result
  logic [2*XLEN-1:0] prod_s, prod_u;
  assign prod_s = $signed({{XLEN{l0_a[XLEN-1]}}, l0_a}) * $signed({{XLEN{l0_b[XLEN-1]}}, l0_b});
  assign prod_u = {{XLEN{1'b0}}, l0_a} * {{XLEN{1'b0}}, l0_b};

`ifdef EXEC_DIV_EN
  localparam logic [4:0]      OP_DIV  = 5'd18;
  localparam logic [4:0]      OP_DIVU = 5'd19;
  localparam int              CNT_W   = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN    = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
  state_t state_q, state_d;

  logic [CNT_W-1:0]      cnt_q;
  logic [XLEN-1:0]       a_q, b_q, rem_q, quo_q, dvs_q, rem_nx, div_hi, div_lo;
  logic                  sgn_q, ge, div_start;
  logic [XLEN:0]         shifted;
  logic [LANES-1:0]      pend_lv_q;
  logic [XLEN*LANES-1:0] pend_res_q;

  assign div_op    = l0_v && (l0_op == OP_DIV || l0_op == OP_DIVU);
  assign div_idle  = (state_q == S_IDLE);
  assign div_start = accept && div_op;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) state_q <= S_IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (div_start) state_d = S_DIV;
      S_DIV:   if (cnt_q == CNT_W'(XLEN)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign ge      = shifted >= {1'b0, dvs_q};
  assign rem_nx  = ge ? XLEN'(shifted - {1'b0, dvs_q}) : shifted[XLEN-1:0];

  // DIV cycle 0 forms operand magnitudes off the accept path; cycles 1..XLEN iterate
  always_ff @(posedge clk_i) begin
    if (div_start) begin
      a_q        <= l0_a;
      b_q        <= l0_b;
      sgn_q      <= (l0_op == OP_DIV);
      cnt_q      <= '0;
      pend_lv_q  <= in_lane_valid_i;
      pend_res_q <= lane_res;
    end else if (state_q == S_DIV) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == '0) begin
        rem_q <= '0;
        quo_q <= (sgn_q && a_q[XLEN-1]) ? -a_q : a_q;
        dvs_q <= (sgn_q && b_q[XLEN-1]) ? -b_q : b_q;
      end else begin
        rem_q <= rem_nx;
        quo_q <= {quo_q[XLEN-2:0], ge};
      end
    end
  end

  always_comb begin
    div_lo = (sgn_q && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_q : quo_q;
    div_hi = (sgn_q && a_q[XLEN-1]) ? -rem_q : rem_q;
    if (b_q == '0) begin
      div_lo = '1;
      div_hi = a_q;
    end else if (sgn_q && a_q == SMIN && b_q == '1) begin
      div_lo = SMIN;
      div_hi = '0;
    end
  end
`else
  assign div_op   = 1'b0;
  assign div_idle = 1'b1;
`endif

  assign in_ready_o = !rst_i && div_idle && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (accept && l0_v) begin
      case (l0_op)
        OP_MTHI:  hi_d = l0_a;
        OP_MTLO:  lo_d = l0_a;
        OP_MULT:  {hi_d, lo_d} = prod_s;
        OP_MULTU: {hi_d, lo_d} = prod_u;
        default:  ;
      endcase
    end
`ifdef EXEC_DIV_EN
    if (state_q == S_DONE) begin
      hi_d = div_hi;
      lo_d = div_lo;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!flush_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // a divide bundle drains the old output at accept and reloads it from DONE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_lv_q    <= '0;
      out_res_q   <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
      out_lv_q    <= '0;
    end
`ifdef EXEC_DIV_EN
    else if (state_q == S_DONE) begin
      out_valid_q <= 1'b1;
      out_lv_q    <= pend_lv_q;
      out_res_q   <= pend_res_q;
    end
`endif
    else if (accept && !div_op) begin
      out_valid_q <= 1'b1;
      out_lv_q    <= in_lane_valid_i;
      out_res_q   <= lane_res;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o      = out_valid_q;
  assign out_lane_valid_o = out_lv_q;
  assign out_result_o     = out_res_q;
endmodule
